// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the two-write/two-read register file.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero/not-ready forcing and optional bypass.
// Bypass compare/mux is built only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = 5
) (
    input  logic              ready,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = mem_data;
`ifdef REGFILE_BYPASS_EN
        // Port 1 checked last so it wins, matching the array's write priority.
        if (we0 && (waddr0 == raddr)) rdata = wdata0;
        if (we1 && (waddr1 == raddr)) rdata = wdata1;
`endif
        if (!ready || (raddr == '0)) rdata = '0;
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{we0, waddr0, wdata0, we1, waddr1, wdata1};
`endif

endmodule

// File: rtl/regfile_2w2r.sv
// Two-write/two-read register file with sequential clear engine; entry 0 reads zero.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-before-write.
module regfile_2w2r
    import regfile_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int DEPTH  = RF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              clr_wr;
    logic              bp_we0;
    logic              bp_we1;

    assign wr_ok  = (state == RF_IDLE) && !rst;
    assign clr_wr = (state == RF_CLEAR) && !rst;
    assign bp_we0 = we0 && wr_ok;
    assign bp_we1 = we1 && wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_ptr <= FIRST;
            ready   <= 1'b0;
        end else begin
            unique case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state   <= RF_CLEAR;
                        clr_ptr <= FIRST;
                        ready   <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state <= RF_IDLE;
                        ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array has no reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            if (we0 && (waddr0 != '0)) mem[waddr0] <= wdata0;
            if (we1 && (waddr1 != '0)) mem[waddr1] <= wdata1;
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd0 (
        .ready    (ready),
        .raddr    (raddr0),
        .mem_data (mem[raddr0]),
        .we0      (bp_we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (bp_we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .rdata    (rdata0)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .ready    (ready),
        .raddr    (raddr1),
        .mem_data (mem[raddr1]),
        .we0      (bp_we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (bp_we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .rdata    (rdata1)
    );

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed self-checking bench for regfile_2w2r (DEPTH=32, DATA_W=32).
// Bypass expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_2w2r;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        ready;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  raddr0, raddr1;
    logic [31:0] rdata0, rdata1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_2w2r dut (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .ready   (ready),
        .we0     (we0),
        .we1     (we1),
        .waddr0  (waddr0),
        .waddr1  (waddr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .raddr0  (raddr0),
        .raddr1  (raddr1),
        .rdata0  (rdata0),
        .rdata1  (rdata1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 0; we0 = 0; we1 = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
        raddr0 = 0; raddr1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        raddr0 = 5'd3; raddr1 = 5'd17;
        repeat (3) tick();
        tests++;
        if (ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready got %b want 0", ready);
        end
        tests++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            fails++; $display("FAIL reset_rdata got %h/%h want 0", rdata0, rdata1);
        end
        rst = 0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            tests++;
            if (ready !== (k == 31)) begin
                fails++; $display("FAIL reset_clear_edge%0d ready got %b want %b", k, ready, k == 31);
            end
        end
        for (int i = 0; i < 32; i++) begin
            raddr0 = 5'(i); raddr1 = 5'(31 - i);
            #1;
            tests++;
            if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
                fails++; $display("FAIL reset_zero a%0d got %h/%h want 0", i, rdata0, rdata1);
            end
        end
    endtask

    task automatic test_basic();
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        we0 = 0; raddr1 = 5'd5;
        #1;
        tests++;
        if (rdata1 !== 32'hDEADBEEF) begin
            fails++; $display("FAIL basic_rd5 got %h want deadbeef", rdata1);
        end
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        tick();
        we0 = 0; raddr0 = 5'd0;
        #1;
        tests++;
        if (rdata0 !== 32'h0) begin
            fails++; $display("FAIL basic_rd0 got %h want 0", rdata0);
        end
    endtask

    task automatic test_collision();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        tick();
        we0 = 0; we1 = 0; raddr0 = 5'd7;
        #1;
        tests++;
        if (rdata0 !== 32'h22222222) begin
            fails++; $display("FAIL collide_rd7 got %h want 22222222", rdata0);
        end
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'hA3A3A3A3;
        we1 = 1; waddr1 = 5'd4; wdata1 = 32'hA4A4A4A4;
        tick();
        we0 = 0; we1 = 0; raddr0 = 5'd3; raddr1 = 5'd4;
        #1;
        tests++;
        if (rdata0 !== 32'hA3A3A3A3 || rdata1 !== 32'hA4A4A4A4) begin
            fails++; $display("FAIL dual_rd3_4 got %h/%h want a3a3a3a3/a4a4a4a4", rdata0, rdata1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h12345678;
        tick();
        we0 = 0;
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'hCAFE0001; raddr0 = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 32'hCAFE0001;
`else
        exp = 32'h12345678;
`endif
        tests++;
        if (rdata0 !== exp) begin
            fails++; $display("FAIL bypass_same got %h want %h", rdata0, exp);
        end
        tick();
        we1 = 0;
        #1;
        tests++;
        if (rdata0 !== 32'hCAFE0001) begin
            fails++; $display("FAIL bypass_next got %h want cafe0001", rdata0);
        end
        we0 = 1; waddr0 = 5'd10; wdata0 = 32'h0000AAAA;
        we1 = 1; waddr1 = 5'd10; wdata1 = 32'h0000BBBB; raddr1 = 5'd10;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 32'h0000BBBB;
`else
        exp = 32'h0;
`endif
        tests++;
        if (rdata1 !== exp) begin
            fails++; $display("FAIL bypass_both got %h want %h", rdata1, exp);
        end
        tick();
        we0 = 0; we1 = 0;
        #1;
        tests++;
        if (rdata1 !== 32'h0000BBBB) begin
            fails++; $display("FAIL bypass_both_next got %h want 0000bbbb", rdata1);
        end
    endtask

    task automatic test_clear_req();
        for (int i = 1; i < 32; i++) begin
            we0 = 1; waddr0 = 5'(i); wdata0 = 32'h10000000 | 32'(i);
            tick();
        end
        we0 = 0; raddr0 = 5'd31; raddr1 = 5'd17;
        #1;
        tests++;
        if (rdata0 !== 32'h1000001F || rdata1 !== 32'h10000011) begin
            fails++; $display("FAIL fill_rd got %h/%h want 1000001f/10000011", rdata0, rdata1);
        end
        clr_req = 1;
        tick();
        clr_req = 0;
        tests++;
        if (ready !== 1'b0) begin
            fails++; $display("FAIL clr_accept ready got %b want 0", ready);
        end
        for (int k = 1; k <= 31; k++) begin
            we0 = 1; waddr0 = 5'd1; wdata0 = 32'hBAD00000 | 32'(k);
            we1 = 1; waddr1 = 5'd30; wdata1 = 32'hBAD10000 | 32'(k);
            #1;
            tests++;
            if (rdata0 !== 32'h0) begin
                fails++; $display("FAIL clr_force k%0d got %h want 0", k, rdata0);
            end
            tick();
            we0 = 0; we1 = 0;
            tests++;
            if (ready !== (k == 31)) begin
                fails++; $display("FAIL clr_edge%0d ready got %b want %b", k, ready, k == 31);
            end
        end
        for (int i = 0; i < 32; i++) begin
            raddr0 = 5'(i); raddr1 = 5'(31 - i);
            #1;
            tests++;
            if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
                fails++; $display("FAIL clr_zero a%0d got %h/%h want 0", i, rdata0, rdata1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (9) tick();
        tests++;
        if (ready !== 1'b0) begin
            fails++; $display("FAIL midclr_busy ready got %b want 0", ready);
        end
        rst = 1;
        tick();
        rst = 0;
        for (int k = 1; k <= 31; k++) begin
            clr_req = (k == 5);
            tick();
            clr_req = 0;
            tests++;
            if (ready !== (k == 31)) begin
                fails++; $display("FAIL midclr_edge%0d ready got %b want %b", k, ready, k == 31);
            end
        end
        tick();
        tests++;
        if (ready !== 1'b1) begin
            fails++; $display("FAIL midclr_noqueue ready got %b want 1", ready);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_basic();
        test_collision();
        test_bypass();
        test_clear_req();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
